wb_regfile: RTL

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile_if.sv | 41 ++++
 rtl/wb_regfile.sv | 89 ++++++++
 2 files changed

// File: rtl/wb_regfile_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile_if
// Brief    : MEM/WB writeback, ID read-port and status bundle for wb_regfile.
// Revision : 1.0  initial release
// ============================================================================
interface wb_regfile_if #(
   parameter int CNT_W = 32
) ();
   logic             wb_valid;
   logic             RegWr_W;
   logic             MemtoReg_W;
   logic [3:0]       NPCop_W;
   logic [4:0]       RegWrDst_W;
   logic [31:0]      PC_W;
   logic [31:0]      result_W;
   logic [31:0]      dout_W;
   logic [4:0]       rs_D;
   logic [4:0]       rt_D;
   logic [31:0]      rd1_D;
   logic [31:0]      rd2_D;
   logic [31:0]      wb_data;
   logic             wb_we;
   logic             last_we;
   logic [4:0]       last_dst;
   logic [31:0]      last_data;
   logic [CNT_W-1:0] instret;

   modport master (
      output wb_valid, RegWr_W, MemtoReg_W, NPCop_W, RegWrDst_W,
             PC_W, result_W, dout_W, rs_D, rt_D,
      input  rd1_D, rd2_D, wb_data, wb_we, last_we, last_dst, last_data, instret
   );

   modport slave (
      input  wb_valid, RegWr_W, MemtoReg_W, NPCop_W, RegWrDst_W,
             PC_W, result_W, dout_W, rs_D, rt_D,
      output rd1_D, rd2_D, wb_data, wb_we, last_we, last_dst, last_data, instret
   );
endinterface
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile
// Brief    : Writeback-stage register file with link select and write bypass.
// Revision : 1.0  initial release
// ============================================================================
module wb_regfile #(
   parameter logic [3:0] LINK_OP = 4'd3,
   parameter int         CNT_W   = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   wb_regfile_if.slave wb
);
   localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [31:0]      w_wb_data;
   logic             w_wb_we;
   logic [31:0]      w_rd1;
   logic [31:0]      w_rd2;
   logic [31:0]      r_regs [0:31];
   logic             r_last_we;
   logic [4:0]       r_last_dst;
   logic [31:0]      r_last_data;
   logic [CNT_W-1:0] r_instret;

   always_comb begin
      if (wb.NPCop_W == LINK_OP)
         w_wb_data = wb.PC_W + 32'd4;
      else if (wb.MemtoReg_W)
         w_wb_data = wb.dout_W;
      else
         w_wb_data = wb.result_W;
   end

   assign w_wb_we = wb.wb_valid & wb.RegWr_W & (wb.RegWrDst_W != 5'd0);

   // Same-cycle bypass lets the ID stage see a value retiring right now.
   always_comb begin
      w_rd1 = r_regs[wb.rs_D];
      if (wb.rs_D == 5'd0)
         w_rd1 = 32'd0;
      else if (w_wb_we && (wb.RegWrDst_W == wb.rs_D))
         w_rd1 = w_wb_data;

      w_rd2 = r_regs[wb.rt_D];
      if (wb.rt_D == 5'd0)
         w_rd2 = 32'd0;
      else if (w_wb_we && (wb.RegWrDst_W == wb.rt_D))
         w_rd2 = w_wb_data;
   end

   // Entry 0 is cleared on reset and never written, so it stays zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++)
            r_regs[i] <= 32'd0;
      end else if (w_wb_we) begin
         r_regs[wb.RegWrDst_W] <= w_wb_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_we   <= 1'b0;
         r_last_dst  <= 5'd0;
         r_last_data <= 32'd0;
         r_instret   <= '0;
      end else begin
         r_last_we <= w_wb_we;
         if (w_wb_we) begin
            r_last_dst  <= wb.RegWrDst_W;
            r_last_data <= w_wb_data;
         end
         if (wb.wb_valid)
            r_instret <= r_instret + c_CNT_ONE;
      end
   end

   assign wb.wb_data   = w_wb_data;
   assign wb.wb_we     = w_wb_we;
   assign wb.rd1_D     = w_rd1;
   assign wb.rd2_D     = w_rd2;
   assign wb.last_we   = r_last_we;
   assign wb.last_dst  = r_last_dst;
   assign wb.last_data = r_last_data;
   assign wb.instret   = r_instret;
endmodule
`default_nettype wire
